// File: rtl/vscale_alu_xvec_seq_if.sv
// vscale_alu_xvec_seq_if
//   Request/response bundle for the sequential xvec vector ALU.
//   master : requester side (register-read stage / testbench)
//   slave  : the ALU itself
//   req_*  : valid/ready request carrying op, vector length and both operand vectors
//   resp_* : valid/ready response carrying the full result vector
interface vscale_alu_xvec_seq_if #(
    parameter int XPR_LEN      = 32,
    parameter int NUM_LANES    = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int VL_W         = $clog2(NUM_LANES + 1)
);
    logic                           req_valid;
    logic                           req_ready;
    logic [ALU_OP_WIDTH-1:0]        req_op;
    logic [VL_W-1:0]                req_vl;
    logic [NUM_LANES*XPR_LEN-1:0]   req_in1;
    logic [NUM_LANES*XPR_LEN-1:0]   req_in2;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [NUM_LANES*XPR_LEN-1:0]   resp_out;

    modport master (
        output req_valid, req_op, req_vl, req_in1, req_in2, resp_ready,
        input  req_ready, resp_valid, resp_out
    );

    modport slave (
        input  req_valid, req_op, req_vl, req_in1, req_in2, resp_ready,
        output req_ready, resp_valid, resp_out
    );
endinterface

// File: rtl/vscale_alu_xvec_seq.sv
// vscale_alu_xvec_seq
//   Multi-cycle vector ALU: accepts one operation, computes LANES_PER_CYCLE
//   lanes per beat up to the run-time vector length, then holds the result
//   until the consumer takes it.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of vscale_alu_xvec_seq_if (request + response handshakes)
//
//   Op encoding (ALU_OP_WIDTH = 4):
//     ADD 0, SLL 1, SGEU 3, XOR 4, SRL 5, OR 6, AND 7,
//     SEQ 8, SNE 9, SUB 10, SRA 11, SLT 12, SGE 13, SLTU 14.
//     Codes 2 and 15 are unassigned and yield all-zero lanes.
module vscale_alu_xvec_seq #(
    parameter int XPR_LEN         = 32,
    parameter int NUM_LANES       = 32,
    parameter int LANES_PER_CYCLE = 4,
    parameter int ALU_OP_WIDTH    = 4,
    parameter int VL_W            = $clog2(NUM_LANES + 1)
) (
    input logic                  clk,
    input logic                  reset,
    vscale_alu_xvec_seq_if.slave bus
);
    localparam int SHAMT_WIDTH = $clog2(XPR_LEN);
    localparam int NUM_BEATS   = NUM_LANES / LANES_PER_CYCLE;
    localparam int BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int LPC_SH      = $clog2(LANES_PER_CYCLE);
    localparam int VEC_W       = NUM_LANES * XPR_LEN;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SGEU = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SEQ  = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SNE  = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SGE  = ALU_OP_WIDTH'(13);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(14);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [BEAT_W-1:0]       last_q, last_d;     // index of the final beat (B-1)
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [VL_W-1:0]         vl_q, vl_d;
    logic [VEC_W-1:0]        in1_q, in1_d;
    logic [VEC_W-1:0]        in2_q, in2_d;
    logic [VEC_W-1:0]        res_q, res_d;

    logic [VL_W-1:0]         vl_clamp;
    logic [VL_W-1:0]         lane_idx;
    logic [XPR_LEN-1:0]      lane_a, lane_b;

    function automatic logic [XPR_LEN-1:0] lane_alu(
        input logic [ALU_OP_WIDTH-1:0] op,
        input logic [XPR_LEN-1:0]      a,
        input logic [XPR_LEN-1:0]      b
    );
        logic [SHAMT_WIDTH-1:0] sh;
        sh = b[SHAMT_WIDTH-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_SEQ:  return XPR_LEN'(a == b);
            OP_SNE:  return XPR_LEN'(a != b);
            OP_SLT:  return XPR_LEN'($signed(a) <  $signed(b));
            OP_SGE:  return XPR_LEN'($signed(a) >= $signed(b));
            OP_SLTU: return XPR_LEN'(a <  b);
            OP_SGEU: return XPR_LEN'(a >= b);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d   = last_q;
        op_d     = op_q;
        vl_d     = vl_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        res_d    = res_q;
        lane_idx = '0;
        lane_a   = '0;
        lane_b   = '0;

        vl_clamp = (bus.req_vl > VL_W'(NUM_LANES)) ? VL_W'(NUM_LANES) : bus.req_vl;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    vl_d    = vl_clamp;
                    in1_d   = bus.req_in1;
                    in2_d   = bus.req_in2;
                    res_d   = '0;
                    beat_d  = '0;
                    // vl = 0 still takes one beat, so the last beat index is 0
                    last_d  = (vl_clamp == '0) ? '0
                            : BEAT_W'((vl_clamp - VL_W'(1)) >> LPC_SH);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                    lane_idx = VL_W'(beat_q) * VL_W'(LANES_PER_CYCLE) + VL_W'(j);
                    lane_a   = in1_q[lane_idx*XPR_LEN +: XPR_LEN];
                    lane_b   = in2_q[lane_idx*XPR_LEN +: XPR_LEN];
                    res_d[lane_idx*XPR_LEN +: XPR_LEN] =
                        (lane_idx < vl_q) ? lane_alu(op_q, lane_a, lane_b) : '0;
                end
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == last_q) begin
                    beat_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= '0;
            op_q    <= '0;
            vl_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            op_q    <= op_d;
            vl_q    <= vl_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            res_q   <= res_d;
        end
    end

    // Handshake outputs decode straight from the state flop so reset reaches them at once
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_out   = res_q;
endmodule

// File: tb/tb_vscale_alu_xvec_seq.sv
// tb_vscale_alu_xvec_seq
//   Table of operations applied one after another; each accepted request pushes
//   its expected vector and beat count onto a scoreboard queue, popped when
//   resp_valid appears. Hand-written sequences cover back-pressure and reset
//   in the middle of BUSY.
module tb_vscale_alu_xvec_seq;
    localparam int XPR_LEN   = 32;
    localparam int NUM_LANES = 32;
    localparam int LPC       = 4;
    localparam int VL_W      = $clog2(NUM_LANES + 1);
    localparam int VEC_W     = NUM_LANES * XPR_LEN;

    typedef logic [VEC_W-1:0] vec_t;

    localparam logic [3:0] OP_ADD = 0,  OP_SLL = 1,  OP_SGEU = 3, OP_XOR = 4,
                           OP_SRL = 5,  OP_OR  = 6,  OP_AND  = 7, OP_SEQ = 8,
                           OP_SNE = 9,  OP_SUB = 10, OP_SRA  = 11, OP_SLT = 12,
                           OP_SGE = 13, OP_SLTU = 14, OP_BAD = 15;

    typedef struct {
        logic [3:0]      op;
        logic [VL_W-1:0] vl;
        vec_t            in1;
        vec_t            in2;
        vec_t            exp;
        int              beats;
        int              hold;    // cycles resp_ready stays low in DONE
    } rec_t;

    typedef struct {
        vec_t exp;
        int   beats;
    } sb_t;

    rec_t tbl[$];
    sb_t  sb_q[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    vscale_alu_xvec_seq_if #(.XPR_LEN(XPR_LEN), .NUM_LANES(NUM_LANES), .ALU_OP_WIDTH(4)) bus ();

    vscale_alu_xvec_seq #(
        .XPR_LEN(XPR_LEN), .NUM_LANES(NUM_LANES), .LANES_PER_CYCLE(LPC), .ALU_OP_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (act[i*XPR_LEN +: XPR_LEN] !== exp[i*XPR_LEN +: XPR_LEN]) begin
                    $display("FAIL %s: lane %0d got %08h expected %08h", name, i,
                             act[i*XPR_LEN +: XPR_LEN], exp[i*XPR_LEN +: XPR_LEN]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [31:0] ref_lane(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a + ~b + 32'd1;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLL:  return a << s;
            OP_SRL:  return a >> s;
            OP_SRA:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            OP_SEQ:  return {31'b0, a == b};
            OP_SNE:  return {31'b0, a != b};
            OP_SLT:  return {31'b0, (a ^ 32'h8000_0000) <  (b ^ 32'h8000_0000)};
            OP_SGE:  return {31'b0, (a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000)};
            OP_SLTU: return {31'b0, a <  b};
            OP_SGEU: return {31'b0, a >= b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_beats(input int vl);
        int v;
        v = (vl > NUM_LANES) ? NUM_LANES : vl;
        return (v == 0) ? 1 : (v + LPC - 1) / LPC;
    endfunction

    function automatic vec_t ref_vec(input logic [3:0] op, input int vl, input vec_t a, input vec_t b);
        vec_t r;
        int   v;
        v = (vl > NUM_LANES) ? NUM_LANES : vl;
        r = '0;
        for (int i = 0; i < v; i++)
            r[i*XPR_LEN +: XPR_LEN] = ref_lane(op, a[i*XPR_LEN +: XPR_LEN], b[i*XPR_LEN +: XPR_LEN]);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < NUM_LANES; i++) r[i*XPR_LEN +: XPR_LEN] = $urandom;
        return r;
    endfunction

    task automatic drive_req(input rec_t r);
        bus.req_valid = 1'b1;
        bus.req_op    = r.op;
        bus.req_vl    = r.vl;
        bus.req_in1   = r.in1;
        bus.req_in2   = r.in2;
    endtask

    task automatic run_rec(input rec_t r, input string tag);
        int   cyc;
        sb_t  e;
        vec_t snap;
        @(negedge clk);
        check({tag, " idle_rdy"}, 64'(bus.req_ready), 64'd1);
        drive_req(r);
        bus.resp_ready = (r.hold == 0);
        @(posedge clk);                      // accept edge
        sb_q.push_back('{exp: r.exp, beats: r.beats});
        #1;
        bus.req_valid = 1'b0;
        bus.req_in1   = rand_vec();          // operands must not matter after accept
        bus.req_in2   = rand_vec();
        check({tag, " busy_rdy"}, 64'(bus.req_ready), 64'd0);
        cyc = 0;
        while (!bus.resp_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.resp_valid) begin
            n_checks++;
            $display("FAIL %s timeout: got no resp_valid expected one within 100 cycles", tag);
            void'(sb_q.pop_front());
            bus.resp_ready = 1'b1;
            return;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s scoreboard: got response expected none", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " latency"}, 64'(cyc), 64'(e.beats));
        check_vec({tag, " out"}, bus.resp_out, e.exp);
        if (r.hold > 0) begin
            snap = bus.resp_out;
            for (int k = 0; k < r.hold; k++) begin
                @(negedge clk);
                bus.req_valid = 1'b1;        // must not be taken outside IDLE
                bus.req_op    = OP_ADD;
                bus.req_vl    = 6'd32;
                @(posedge clk); #1;
                check({tag, " hold_vld"}, 64'(bus.resp_valid), 64'd1);
                check({tag, " hold_rdy"}, 64'(bus.req_ready), 64'd0);
                check_vec({tag, " hold_out"}, bus.resp_out, snap);
            end
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;                  // consume edge
        check({tag, " consumed_vld"}, 64'(bus.resp_valid), 64'd0);
        check({tag, " consumed_rdy"}, 64'(bus.req_ready), 64'd1);
    endtask

    vec_t a, b, x;
    rec_t r;
    logic [3:0] rops [14] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL,
                              OP_SRA, OP_SEQ, OP_SNE, OP_SLT, OP_SGE, OP_SLTU, OP_SGEU};

    initial begin
        int seen;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_vl     = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.resp_ready = 1'b1;

        // ---- table: directed entries ----
        for (int i = 0; i < NUM_LANES; i++) begin
            a[i*32 +: 32] = i;
            b[i*32 +: 32] = 100;
            x[i*32 +: 32] = 100 + i;
        end
        tbl.push_back('{op: OP_ADD, vl: 6'd32, in1: a, in2: b, exp: x, beats: 8, hold: 0});
        tbl.push_back('{op: OP_ADD, vl: 6'd40, in1: a, in2: b, exp: x, beats: 8, hold: 0});

        x = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            a[i*32 +: 32] = 10;
            b[i*32 +: 32] = 3;
            if (i < 5) x[i*32 +: 32] = 7;
        end
        tbl.push_back('{op: OP_SUB, vl: 6'd5, in1: a, in2: b, exp: x, beats: 2, hold: 5});

        a = '0; b = '0;
        a[0 +: 32]  = 32'hFFFF_FFFF; b[0 +: 32]  = 32'd1;
        a[96 +: 32] = 32'h8000_0000; b[96 +: 32] = 32'd4;
        x = '0; x[0 +: 32] = 1; x[96 +: 32] = 1;
        tbl.push_back('{op: OP_SLT, vl: 6'd4, in1: a, in2: b, exp: x, beats: 1, hold: 0});
        x = '0;
        tbl.push_back('{op: OP_SLTU, vl: 6'd4, in1: a, in2: b, exp: x, beats: 1, hold: 0});
        x = '0; x[0 +: 32] = 1; x[32 +: 32] = 1; x[64 +: 32] = 1; x[96 +: 32] = 1;
        tbl.push_back('{op: OP_SGEU, vl: 6'd4, in1: a, in2: b, exp: x, beats: 1, hold: 0});
        x = '0; x[0 +: 32] = 32'hFFFF_FFFF; x[96 +: 32] = 32'hF800_0000;
        tbl.push_back('{op: OP_SRA, vl: 6'd4, in1: a, in2: b, exp: x, beats: 1, hold: 0});

        a = rand_vec(); b = rand_vec();
        tbl.push_back('{op: OP_ADD, vl: 6'd0, in1: a, in2: b, exp: '0, beats: 1, hold: 0});
        tbl.push_back('{op: OP_BAD, vl: 6'd32, in1: a, in2: b, exp: '0, beats: 8, hold: 0});

        // ---- table: random entries, one per op, model-derived expectations ----
        for (int k = 0; k < 14; k++) begin
            int v;
            a = rand_vec(); b = rand_vec();
            for (int i = 0; i < NUM_LANES; i++)
                if ($urandom_range(0, 3) == 0) b[i*32 +: 32] = a[i*32 +: 32];
            v = $urandom_range(0, 40);
            r = '{op: rops[k], vl: 6'(v), in1: a, in2: b, exp: ref_vec(rops[k], v, a, b),
                  beats: ref_beats(v), hold: (k == 6) ? 2 : 0};
            tbl.push_back(r);
        end

        // ---- reset state ----
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_vec("rst_resp_out", bus.resp_out, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_rec(tbl[i], $sformatf("vec%0d", i));

        // ---- reset in the middle of BUSY (beat 3 of 8) ----
        @(negedge clk);
        drive_req(tbl[0]);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_vec("midrst_resp_out", bus.resp_out, '0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        check("midrst_no_resp", 64'(seen), 64'd0);
        check("midrst_rdy_after", 64'(bus.req_ready), 64'd1);
        run_rec(tbl[2], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vscale_alu_xvec_seq.md
# vscale_alu_xvec_seq

Multi-cycle, parametrised vector ALU for the xvec extension. It accepts one vector operation through a valid/ready request port and processes `LANES_PER_CYCLE` lanes per clock up to a run-time vector length. It returns the full vector result through a valid/ready response port. It sits between the xvec register-read stage and writeback, where it replaces the single-cycle all-lane ALU whenever area must be traded for latency. Compared with that ALU it adds run-time vector length, per-lane compare and shift semantics, and back-pressure.

## Interface
- `XPR_LEN`, 32, lane width in bits.
- `NUM_LANES`, 32, lanes per vector; power of two, ≥ 1.
- `LANES_PER_CYCLE`, 4, lanes computed per beat; power of two, divides `NUM_LANES`.
- `VL_W`, $clog2(NUM_LANES+1), width of the vector-length field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  `ALU_OP_WIDTH`  operation, encoded per `vscale_alu_ops.vh`.
- `req_vl`  in  VL_W  active lane count; values above NUM_LANES clamp to NUM_LANES.
- `req_in1`, `req_in2`  in  NUM_LANES*XPR_LEN  operands; lane i occupies bits [i*XPR_LEN +: XPR_LEN].
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_out`  out  NUM_LANES*XPR_LEN  result vector, registered.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when `req_valid && req_ready`. At this transition the block latches op, clamped vl and both operands, clears the result register to 0, and sets `beat` = 0.
  - BUSY, each cycle: computes lanes [beat*LPC, beat*LPC+LPC-1]. Lanes with index ≥ vl are written 0. `beat` increments. After beat B-1 the FSM moves to DONE.
  - B = max(1, ceil(vl/LANES_PER_CYCLE)).
  - DONE: `resp_valid` = 1. On `resp_ready` the FSM returns to IDLE.
- Per-lane ops; all operate on every active lane, unlike the scalar-only compares of the previous ALU:
  - ADD, SUB: modulo 2^XPR_LEN.
  - XOR, OR, AND.
  - SLL, SRL, SRA: shift amount is the lane's own in2[`SHAMT_WIDTH`-1:0]; SRA is arithmetic.
  - SEQ, SNE, SLT, SGE (signed), SLTU, SGEU (unsigned): result is zero-extended 1 or 0.
- Any unlisted op code produces all-zero lanes, with the same timing as a listed op.
- vl = 0: one beat; the result is all zeros.
- Operand inputs are don't-care after acceptance; the block uses only the latched copies.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `req_ready`: 1.
  - `resp_valid`: 0.
  - `resp_out`: 0.
  - `beat`: 0.
- Request accepted at edge t. BUSY occupies cycles t..t+B-1. `resp_valid` rises after edge t+B.
- With `resp_ready` held high, the response is consumed at edge t+B+1. `req_ready` is high again in the following cycle.
- Minimum initiation interval is B+2 cycles. The block holds no second request while in BUSY or DONE.
- While `resp_valid` is high and `resp_ready` is low, `resp_out` and `resp_valid` stay stable indefinitely.
- `resp_out` is only guaranteed meaningful while `resp_valid` is high. Partially computed lanes may be visible during BUSY.
- Reset asserted mid-BUSY or mid-DONE:
  - Outputs go immediately (asynchronously) to their reset values.
  - The in-flight operation is discarded and no response is produced.
- `req_valid` must not be interpreted as consuming anything while in BUSY or DONE.

## Test plan
- ADD, vl=32, LPC=4, lane i: in1=i, in2=100 → lane i = 100+i; `resp_valid` high exactly 8 cycles after the accept edge (B=8).
- SUB, vl=5, in1=10, in2=3 on all lanes → lanes 0..4 = 7 and lanes 5..31 = 0; B=2.
- SLT/SLTU/SRA, lane 0: in1=0xFFFFFFFF, in2=1 → SLT gives 1, SLTU gives 0. SRA on lane 3 with in1=0x80000000, in2=4 → 0xF8000000, confirming the per-lane shift amount.
- vl=0 with ADD, and unknown op 0xF with vl=32:
  - vl=0 → all zeros after 1 beat.
  - Unknown op → all zeros after 8 beats.
  - vl=40 → clamps to 32.
- Back-pressure: `resp_ready` held low for 5 cycles in DONE → `resp_out` and `resp_valid` stable and `req_ready` = 0. Dropping `resp_ready` and then raising it → IDLE next cycle and the next request is accepted.
- Reset asserted during BUSY beat 3 → `resp_valid` = 0 and `resp_out` = 0 immediately, `req_ready` = 1 after release, and the next op completes correctly.
